// File: rtl/z80_bus_bridge_if.sv
// Z80 strobes plus backend request/ack bundle for z80_bus_bridge.
// master = the bridge, slave = the Z80 side and backend together.
interface z80_bus_bridge_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic          CEN_P;
  logic          CEN_N;
  logic          Z_nMREQ;
  logic          Z_nIORQ;
  logic          Z_nRD;
  logic          Z_nWR;
  logic          Z_nRFSH;
  logic [AW-1:0] Z_A;
  logic [DW-1:0] Z_DO;
  logic [DW-1:0] Z_DI;
  logic          Z_nWAIT;
  logic          B_REQ;
  logic          B_WE;
  logic          B_IO;
  logic [AW-1:0] B_ADDR;
  logic [DW-1:0] B_WDATA;
  logic [DW-1:0] B_RDATA;
  logic          B_ACK;
  logic          B_TMO;

  modport master (
    output CEN_P, CEN_N,
    input  Z_nMREQ, Z_nIORQ, Z_nRD, Z_nWR, Z_nRFSH,
    input  Z_A, Z_DO,
    output Z_DI, Z_nWAIT,
    output B_REQ, B_WE, B_IO, B_ADDR, B_WDATA, B_TMO,
    input  B_RDATA, B_ACK
  );

  modport slave (
    input  CEN_P, CEN_N,
    output Z_nMREQ, Z_nIORQ, Z_nRD, Z_nWR, Z_nRFSH,
    output Z_A, Z_DO,
    input  Z_DI, Z_nWAIT,
    input  B_REQ, B_WE, B_IO, B_ADDR, B_WDATA, B_TMO,
    output B_RDATA, B_ACK
  );
endinterface

// File: rtl/z80_bus_bridge.sv
// Z80 clock-enable generator and strobe-to-backend request bridge.
// One backend request per Z80 access; Z80 is held with nWAIT until done.
module z80_bus_bridge #(
  parameter int CLK_DIV = 6,
  parameter int AW      = 16,
  parameter int DW      = 8,
  parameter int TIMEOUT = 255
) (
  input logic              CLK,
  input logic              RESET,
  z80_bus_bridge_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WACK,
    DONE
  } state_t;

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2 - 1);
  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT);

  state_t     state;
  state_t     state_nx;
  logic [DIV_W-1:0] div;
  logic       cen_run;
  logic [15:0] tmo_cnt;
  logic       access;
  logic       tmo_hit;

  always_comb begin
    access = 1'b0;
    if (!bus.Z_nMREQ && bus.Z_nRFSH && (!bus.Z_nRD || !bus.Z_nWR))
      access = 1'b1;
    if (!bus.Z_nIORQ && (!bus.Z_nRD || !bus.Z_nWR))
      access = 1'b1;
  end

  assign tmo_hit = (tmo_cnt == TMO_LIM);

  // CEN_N stays quiet until the first CEN_P so it always trails it
  always_ff @(posedge CLK) begin
    if (RESET) begin
      div       <= '0;
      cen_run   <= 1'b0;
      bus.CEN_P <= 1'b0;
      bus.CEN_N <= 1'b0;
    end else begin
      div       <= (div == DIV_LAST) ? '0 : div + 1'b1;
      bus.CEN_P <= (div == DIV_LAST);
      bus.CEN_N <= cen_run && (div == DIV_HALF);
      if (div == DIV_LAST)
        cen_run <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (access) state_nx = REQ;
      REQ:  state_nx = WACK;
      WACK: if (bus.B_ACK || tmo_hit) state_nx = DONE;
      DONE: if (!access) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      bus.B_ADDR  <= '0;
      bus.B_WDATA <= '0;
      bus.B_WE    <= 1'b0;
      bus.B_IO    <= 1'b0;
      bus.Z_DI    <= '1;
      tmo_cnt     <= '0;
    end else begin
      if (state == IDLE && access) begin
        bus.B_ADDR  <= bus.Z_A;
        bus.B_WDATA <= bus.Z_DO;
        bus.B_WE    <= ~bus.Z_nWR;
        bus.B_IO    <= ~bus.Z_nIORQ;
      end
      if (state == REQ)
        tmo_cnt <= '0;
      else if (state == WACK && !tmo_hit)
        tmo_cnt <= tmo_cnt + 16'd1;
      // ack wins over a timeout landing in the same cycle
      if (state == WACK) begin
        if (bus.B_ACK) begin
          if (!bus.B_WE)
            bus.Z_DI <= bus.B_RDATA;
        end else if (tmo_hit) begin
          bus.Z_DI <= '1;
        end
      end
    end
  end

  assign bus.B_REQ = !RESET && (state == REQ);
  assign bus.B_TMO = !RESET && (state == WACK)
                     && tmo_hit && !bus.B_ACK;
  assign bus.Z_nWAIT = RESET || !(access && state != DONE);

endmodule

// File: tb/tb_z80_bus_bridge.sv
// Directed bench for z80_bus_bridge: divider, access table,
// timeout, ack/timeout race, aborted cycle and mid-transaction reset.
module tb_z80_bus_bridge;

  typedef struct {
    logic        mreq;
    logic        iorq;
    logic        rd;
    logic        wr;
    logic        rfsh;
    logic [15:0] addr;
    logic [7:0]  dout;
    logic [7:0]  rdata;
    logic        req;
    logic        we;
    logic        io;
  } vec_t;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  int         checks = 0;
  int         failures = 0;
  int         req_cnt = 0;
  int         tmo_cnt = 0;
  logic [7:0] exp_di = 8'hFF;
  vec_t       vt [8];

  z80_bus_bridge_if #(.AW(16), .DW(8)) bus ();

  z80_bus_bridge #(
    .CLK_DIV(6),
    .AW     (16),
    .DW     (8),
    .TIMEOUT(4)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (bus.B_REQ) req_cnt <= req_cnt + 1;
    if (bus.B_TMO) tmo_cnt <= tmo_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_strobes();
    bus.Z_nMREQ = 1'b1;
    bus.Z_nIORQ = 1'b1;
    bus.Z_nRD   = 1'b1;
    bus.Z_nWR   = 1'b1;
    bus.Z_nRFSH = 1'b1;
  endtask

  task automatic chk_reset(input string t);
    chk({t, "_cen_p"}, 32'(bus.CEN_P), 0);
    chk({t, "_cen_n"}, 32'(bus.CEN_N), 0);
    chk({t, "_b_req"}, 32'(bus.B_REQ), 0);
    chk({t, "_b_we"}, 32'(bus.B_WE), 0);
    chk({t, "_b_io"}, 32'(bus.B_IO), 0);
    chk({t, "_b_addr"}, 32'(bus.B_ADDR), 0);
    chk({t, "_b_wdata"}, 32'(bus.B_WDATA), 0);
    chk({t, "_b_tmo"}, 32'(bus.B_TMO), 0);
    chk({t, "_z_di"}, 32'(bus.Z_DI), 32'hFF);
    chk({t, "_nwait"}, 32'(bus.Z_nWAIT), 1);
  endtask

  task automatic start_read(input logic [15:0] a);
    bus.Z_A     = a;
    bus.Z_nMREQ = 1'b0;
    bus.Z_nRD   = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int    r0;
    string n;
    r0 = req_cnt;
    n = $sformatf("vec%0d", idx);
    bus.Z_A     = v.addr;
    bus.Z_DO    = v.dout;
    bus.Z_nMREQ = v.mreq;
    bus.Z_nIORQ = v.iorq;
    bus.Z_nRD   = v.rd;
    bus.Z_nWR   = v.wr;
    bus.Z_nRFSH = v.rfsh;
    #1;
    chk({n, "_nwait_idle"}, 32'(bus.Z_nWAIT), 32'(!v.req));
    tick();
    chk({n, "_b_req"}, 32'(bus.B_REQ), 32'(v.req));
    if (v.req) begin
      chk({n, "_b_addr"}, 32'(bus.B_ADDR), 32'(v.addr));
      chk({n, "_b_we"}, 32'(bus.B_WE), 32'(v.we));
      chk({n, "_b_io"}, 32'(bus.B_IO), 32'(v.io));
      chk({n, "_b_wdata"}, 32'(bus.B_WDATA), 32'(v.dout));
      repeat (3) tick();
      chk({n, "_nwait_wack"}, 32'(bus.Z_nWAIT), 0);
      bus.B_ACK   = 1'b1;
      bus.B_RDATA = v.rdata;
      tick();
      bus.B_ACK = 1'b0;
      if (!v.we) exp_di = v.rdata;
      chk({n, "_z_di"}, 32'(bus.Z_DI), 32'(exp_di));
      chk({n, "_nwait_done"}, 32'(bus.Z_nWAIT), 1);
      repeat (20) tick();
      chk({n, "_nwait_hold"}, 32'(bus.Z_nWAIT), 1);
      chk({n, "_one_req"}, 32'(req_cnt), 32'(r0 + 1));
      chk({n, "_addr_stable"}, 32'(bus.B_ADDR), 32'(v.addr));
    end else begin
      repeat (4) tick();
      chk({n, "_nwait_ign"}, 32'(bus.Z_nWAIT), 1);
      chk({n, "_no_req"}, 32'(req_cnt), 32'(r0));
    end
    idle_strobes();
    repeat (2) tick();
  endtask

  initial begin
    int r0;
    int t0;
    vt[0] = '{0, 1, 0, 1, 1, 16'h1234, 8'h00, 8'h5A, 1, 0, 0};
    vt[1] = '{1, 0, 1, 0, 1, 16'h0008, 8'hC3, 8'h00, 1, 1, 1};
    vt[2] = '{0, 1, 1, 0, 1, 16'hABCD, 8'h77, 8'hEE, 1, 1, 0};
    vt[3] = '{1, 0, 0, 1, 1, 16'h00FE, 8'h00, 8'h3C, 1, 0, 1};
    vt[4] = '{0, 1, 1, 1, 0, 16'h0100, 8'h00, 8'h00, 0, 0, 0};
    vt[5] = '{0, 1, 0, 1, 0, 16'h0101, 8'h00, 8'h00, 0, 0, 0};
    vt[6] = '{1, 0, 1, 1, 1, 16'h0038, 8'h00, 8'h00, 0, 0, 0};
    vt[7] = '{0, 1, 1, 1, 1, 16'h0200, 8'h00, 8'h00, 0, 0, 0};

    idle_strobes();
    bus.Z_A     = '0;
    bus.Z_DO    = '0;
    bus.B_ACK   = 1'b0;
    bus.B_RDATA = '0;
    RESET = 1'b1;
    repeat (3) tick();
    chk_reset("rst");

    RESET = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      chk($sformatf("cen_p_c%0d", n), 32'(bus.CEN_P),
          32'(n % 6 == 0));
      chk($sformatf("cen_n_c%0d", n), 32'(bus.CEN_N),
          32'(n >= 9 && n % 6 == 3));
      chk($sformatf("cen_excl_c%0d", n),
          32'(bus.CEN_P & bus.CEN_N), 0);
    end

    for (int i = 0; i < 8; i++) run_vec(vt[i], i);

    // timeout with a late ack that must be ignored
    t0 = tmo_cnt;
    start_read(16'h4000);
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("tmo_early%0d", k), 32'(bus.B_TMO), 0);
      tick();
    end
    chk("tmo_pulse", 32'(bus.B_TMO), 1);
    chk("tmo_nwait_low", 32'(bus.Z_nWAIT), 0);
    tick();
    exp_di = 8'hFF;
    chk("tmo_after", 32'(bus.B_TMO), 0);
    chk("tmo_z_di", 32'(bus.Z_DI), 32'(exp_di));
    chk("tmo_nwait", 32'(bus.Z_nWAIT), 1);
    bus.B_ACK   = 1'b1;
    bus.B_RDATA = 8'h11;
    repeat (3) tick();
    chk("tmo_late_ack_di", 32'(bus.Z_DI), 32'(exp_di));
    chk("tmo_once", 32'(tmo_cnt), 32'(t0 + 1));
    idle_strobes();
    tick();
    bus.B_ACK = 1'b0;
    repeat (2) tick();

    // ack coincides with timeout: ack wins
    t0 = tmo_cnt;
    start_read(16'h5000);
    tick();
    tick();
    repeat (4) tick();
    bus.B_ACK   = 1'b1;
    bus.B_RDATA = 8'h99;
    #1;
    chk("race_tmo", 32'(bus.B_TMO), 0);
    tick();
    bus.B_ACK = 1'b0;
    exp_di = 8'h99;
    chk("race_z_di", 32'(bus.Z_DI), 32'(exp_di));
    chk("race_no_tmo", 32'(tmo_cnt), 32'(t0));
    idle_strobes();
    repeat (2) tick();

    // strobes vanish during REQ; backend still completes
    r0 = req_cnt;
    start_read(16'h6000);
    tick();
    idle_strobes();
    tick();
    chk("abort_nwait", 32'(bus.Z_nWAIT), 1);
    tick();
    bus.B_ACK   = 1'b1;
    bus.B_RDATA = 8'h42;
    tick();
    bus.B_ACK = 1'b0;
    exp_di = 8'h42;
    chk("abort_z_di", 32'(bus.Z_DI), 32'(exp_di));
    repeat (3) tick();
    chk("abort_one_req", 32'(req_cnt), 32'(r0 + 1));

    // reset while waiting for ack
    r0 = req_cnt;
    t0 = tmo_cnt;
    start_read(16'h2222);
    tick();
    tick();
    tick();
    RESET = 1'b1;
    idle_strobes();
    tick();
    chk_reset("mid");
    bus.B_ACK   = 1'b1;
    bus.B_RDATA = 8'h77;
    tick();
    RESET = 1'b0;
    repeat (5) tick();
    chk("post_cen_p_c5", 32'(bus.CEN_P), 0);
    tick();
    chk("post_cen_p_c6", 32'(bus.CEN_P), 1);
    repeat (4) tick();
    bus.B_ACK = 1'b0;
    exp_di = 8'hFF;
    chk("post_z_di", 32'(bus.Z_DI), 32'(exp_di));
    chk("post_no_tmo", 32'(tmo_cnt), 32'(t0));
    chk("post_one_req", 32'(req_cnt), 32'(r0 + 1));
    chk("post_b_addr", 32'(bus.B_ADDR), 0);
    chk("post_nwait", 32'(bus.Z_nWAIT), 1);

    // idle after reset: a new read must be accepted immediately
    start_read(16'h0F0F);
    tick();
    chk("post_new_req", 32'(bus.B_REQ), 1);
    idle_strobes();
    tick();
    tick();
    bus.B_ACK   = 1'b1;
    bus.B_RDATA = 8'h21;
    tick();
    bus.B_ACK = 1'b0;
    chk("post_new_di", 32'(bus.Z_DI), 32'h21);
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/z80_bus_bridge.md
Z80_BUS_BRIDGE -- requirements
Module: z80_bus_bridge

Interface
REQ-001 Parameter CLK_DIV, default 6, SHALL set the master-clock cycles per Z80 clock; it SHALL be even and at least 2.
REQ-002 Parameter AW, default 16, SHALL set the address width.
REQ-003 Parameter DW, default 8, SHALL set the data width.
REQ-004 Parameter TIMEOUT, default 255, SHALL set the maximum cycles spent waiting for B_ACK, in range 1..65535.
REQ-005 The block SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-006 CLK  in  1  master clock.
REQ-007 RESET  in  1  synchronous active-high reset.
REQ-008 CEN_P / CEN_N  out  1 each  Z80 positive/negative clock-enable pulses.
REQ-009 Z_nMREQ, Z_nIORQ, Z_nRD, Z_nWR, Z_nRFSH  in  1 each  Z80 strobes, active-low.
REQ-010 Z_A  in  AW  Z80 address; Z_DO  in  DW  Z80 write data.
REQ-011 Z_DI  out  DW  read data to Z80; Z_nWAIT  out  1  wait request to Z80, active-low.
REQ-012 B_REQ  out  1  one-cycle request pulse to the memory/IO backend.
REQ-013 B_WE, B_IO  out  1 each  write and IO-space qualifiers; B_ADDR  out  AW; B_WDATA  out  DW.
REQ-014 B_RDATA  in  DW  backend read data; B_ACK  in  1  backend completion.
REQ-015 B_TMO  out  1  one-cycle timeout pulse.

Function
REQ-016 Divider SHALL count 0..CLK_DIV-1 and wrap; CEN_P SHALL be high exactly one cycle per CLK_DIV cycles, first in cycle CLK_DIV after RESET falls; CEN_N SHALL pulse exactly CLK_DIV/2 cycles after each CEN_P.
REQ-017 A qualifying access SHALL be a memory access (Z_nMREQ=0, Z_nRFSH=1, Z_nRD=0 or Z_nWR=0) or an IO access (Z_nIORQ=0, Z_nRD=0 or Z_nWR=0); refresh cycles and interrupt-acknowledge cycles (IORQ without RD/WR) SHALL be ignored.
REQ-018 FSM states SHALL be IDLE, REQ, WACK, DONE.
REQ-019 IDLE->REQ on a qualifying access; on this transition B_ADDR, B_WDATA, B_WE (=~Z_nWR) and B_IO (=~Z_nIORQ) SHALL be latched.
REQ-020 B_REQ SHALL be high for the single cycle spent in REQ; REQ->WACK unconditionally; the timeout counter SHALL clear on entry to WACK.
REQ-021 B_ACK SHALL be honoured only in WACK and ignored in every other state.
REQ-022 In WACK with B_ACK=1, Z_DI SHALL load B_RDATA when B_WE=0 (Z_DI unchanged on writes), then go to DONE.
REQ-023 In WACK, when the counter reaches TIMEOUT without B_ACK, Z_DI SHALL load all ones, B_TMO SHALL pulse one cycle, then go to DONE; B_ACK arriving in that same cycle SHALL take priority and suppress B_TMO.
REQ-024 Z_nWAIT SHALL be driven combinationally low whenever a qualifying access is present and state is not DONE; it SHALL be high otherwise.
REQ-025 DONE->IDLE SHALL occur only once no qualifying access is present, so one Z80 cycle yields exactly one B_REQ.
REQ-026 B_ADDR, B_WDATA, B_WE and B_IO SHALL hold stable from REQ until the next IDLE->REQ transition.
REQ-027 Strobes deasserting in REQ or WACK (aborted cycle) SHALL NOT cancel the backend transaction; completion SHALL proceed to DONE and then to IDLE.

Reset
REQ-028 While RESET=1 the block SHALL hold: state IDLE, divider 0, CEN_P=0, CEN_N=0, B_REQ=0, B_WE=0, B_IO=0, B_ADDR=0, B_WDATA=0, B_TMO=0, Z_DI=all ones, Z_nWAIT=1.
REQ-029 Reset asserted mid-transaction SHALL abandon the transaction, issuing no further B_REQ and no B_TMO.

Verification
REQ-030 CLK_DIV=6, release reset -> CEN_P in cycles 6, 12, 18; CEN_N in cycles 9, 15; never both high.
REQ-031 Memory read A=0x1234, B_ACK with B_RDATA=0x5A three cycles after B_REQ -> exactly one B_REQ with B_ADDR=0x1234, B_WE=0, B_IO=0; Z_DI=0x5A; Z_nWAIT low until ACK+1.
REQ-032 IO write A=0x0008, Z_DO=0xC3 -> B_IO=1, B_WE=1, B_WDATA=0xC3; Z_DI unchanged; one B_REQ only, with strobes held 20 cycles after ACK.
REQ-033 TIMEOUT=4, read with no B_ACK -> B_TMO pulses once 4 cycles after WACK entry, Z_DI=0xFF, Z_nWAIT high; B_ACK arriving later is ignored.
REQ-034 Refresh (Z_nMREQ=0, Z_nRFSH=0), then M1 interrupt acknowledge (Z_nIORQ=0, RD/WR high) -> no B_REQ, Z_nWAIT stays 1.
REQ-035 RESET pulsed while in WACK, then B_ACK -> no B_TMO, no Z_DI update, state IDLE, all REQ-028 values.
